// File: rtl/alu_pkg.sv
// Shared types for the multi-cycle ALU: opcodes, flag bit positions and FSM states.
package alu_pkg;

  typedef enum logic [3:0] {
    OpAdd = 4'b0000,
    OpSub = 4'b0001,
    OpShl = 4'b0010,
    OpShr = 4'b0011,
    OpOr  = 4'b0100,
    OpAnd = 4'b0101,
    OpXor = 4'b0110,
    OpNot = 4'b0111,
    OpMul = 4'b1000,
    OpAsr = 4'b1001
  } op_e;

  localparam int unsigned FlagZ = 0;
  localparam int unsigned FlagV = 1;
  localparam int unsigned FlagN = 2;
  localparam int unsigned FlagC = 3;

  typedef enum logic [1:0] {
    StIdle,
    StExec,
    StDone
  } state_e;

endpackage

// File: rtl/alu_flag_gen.sv
// Combinational Z/V/N/C generation from a final result and the raw carry/overflow.
module alu_flag_gen
  import alu_pkg::*;
#(
  parameter int unsigned BITS = 8
) (
  input  op_e             opcode_i,
  input  logic [BITS-1:0] result_i,
  input  logic            carry_i,
  input  logic            overflow_i,
  output logic [3:0]      flags_o
);

  always_comb begin
    flags_o        = '0;
    flags_o[FlagZ] = (result_i == '0);
    flags_o[FlagN] = result_i[BITS-1];
    case (opcode_i)
      OpAdd, OpSub: begin
        flags_o[FlagC] = carry_i;
        flags_o[FlagV] = overflow_i;
      end
      OpShl, OpShr, OpAsr, OpMul: flags_o[FlagC] = carry_i;
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_multicycle.sv
// Multi-cycle ALU: single-cycle arithmetic/logic, bit-serial shifts and shift-add multiply,
// with a valid/ready handshake on both the request and the result side.
module alu_multicycle
  import alu_pkg::*;
#(
  parameter int unsigned BITS = 8
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [BITS-1:0] bus_a_i,
  input  logic [BITS-1:0] bus_b_i,
  input  logic [3:0]      control_i,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [BITS-1:0] bus_s_o,
  output logic [3:0]      flags_o
);

  localparam int unsigned     CntW     = $clog2(BITS + 1);
  localparam logic [BITS-1:0] BitsVal  = BITS'(BITS);
  localparam logic [CntW-1:0] CntFull  = CntW'(BITS);

  state_e            state_q, state_d;
  op_e               op_q, op_d;
  logic [2*BITS-1:0] work_q, work_d;  // shift register, or {partial product, multiplier}
  logic [BITS-1:0]   mcand_q, mcand_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [BITS-1:0]   res_q, res_d;
  logic [3:0]        flags_q, flags_d;

  op_e             op_in;
  logic [CntW-1:0] k_in;
  logic            load, go_exec, step_c;
  op_e             fin_op;
  logic [BITS-1:0] fin_res;
  logic            fin_c, fin_v;
  logic [BITS:0]   mul_sum;
  logic [3:0]      fin_flags;

  assign op_in = op_e'(control_i);
  assign k_in  = (bus_b_i >= BitsVal) ? CntFull : CntW'(bus_b_i);

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    work_d  = work_q;
    mcand_d = mcand_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    go_exec = 1'b0;
    fin_op  = op_q;
    fin_res = '0;
    fin_c   = 1'b0;
    fin_v   = 1'b0;
    step_c  = 1'b0;
    mul_sum = '0;
    unique case (state_q)
      StIdle: begin
        fin_op = op_in;
        case (op_in)
          OpAdd: begin
            {fin_c, fin_res} = {1'b0, bus_a_i} + {1'b0, bus_b_i};
            fin_v = (bus_a_i[BITS-1] == bus_b_i[BITS-1]) && (fin_res[BITS-1] != bus_a_i[BITS-1]);
          end
          OpSub: begin
            {fin_c, fin_res} = {1'b0, bus_a_i} + {1'b0, ~bus_b_i} + {{BITS{1'b0}}, 1'b1};
            fin_v = (bus_a_i[BITS-1] != bus_b_i[BITS-1]) && (fin_res[BITS-1] != bus_a_i[BITS-1]);
          end
          OpShl, OpShr, OpAsr: begin
            fin_res = bus_a_i;
            go_exec = (k_in != '0);
          end
          OpOr:  fin_res = bus_a_i | bus_b_i;
          OpAnd: fin_res = bus_a_i & bus_b_i;
          OpXor: fin_res = bus_a_i ^ bus_b_i;
          OpNot: fin_res = ~bus_a_i;
          OpMul: go_exec = 1'b1;
          default: ;
        endcase
        if (valid_i) begin
          op_d    = op_in;
          mcand_d = bus_a_i;
          cnt_d   = (op_in == OpMul) ? CntFull : k_in;
          work_d  = (op_in == OpMul) ? {{BITS{1'b0}}, bus_b_i} : {{BITS{1'b0}}, bus_a_i};
          if (go_exec) begin
            state_d = StExec;
          end else begin
            state_d = StDone;
            load    = 1'b1;
          end
        end
      end
      StExec: begin
        case (op_q)
          OpShl: begin
            step_c = work_q[BITS-1];
            work_d = {{BITS{1'b0}}, work_q[BITS-2:0], 1'b0};
          end
          OpShr: begin
            step_c = work_q[0];
            work_d = {{BITS{1'b0}}, 1'b0, work_q[BITS-1:1]};
          end
          OpAsr: begin
            step_c = work_q[0];
            work_d = {{BITS{1'b0}}, work_q[BITS-1], work_q[BITS-1:1]};
          end
          default: begin
            // Shift-add step: conditionally add multiplicand to upper half, shift right.
            mul_sum = {1'b0, work_q[2*BITS-1:BITS]} +
                      {1'b0, (work_q[0] ? mcand_q : {BITS{1'b0}})};
            work_d  = {mul_sum, work_q[BITS-1:1]};
          end
        endcase
        cnt_d   = cnt_q - 1'b1;
        fin_res = work_d[BITS-1:0];
        fin_c   = (op_q == OpMul) ? (work_d[2*BITS-1:BITS] != '0) : step_c;
        if (cnt_q == CntW'(1)) begin
          state_d = StDone;
          load    = 1'b1;
        end
      end
      StDone: begin
        if (ready_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  alu_flag_gen #(
    .BITS(BITS)
  ) u_flag_gen (
    .opcode_i  (fin_op),
    .result_i  (fin_res),
    .carry_i   (fin_c),
    .overflow_i(fin_v),
    .flags_o   (fin_flags)
  );

  always_comb begin
    res_d   = res_q;
    flags_d = flags_q;
    if (load) begin
      res_d   = fin_res;
      flags_d = fin_flags;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      op_q    <= OpAdd;
      work_q  <= '0;
      mcand_q <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      work_q  <= work_d;
      mcand_q <= mcand_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      flags_q <= flags_d;
    end
  end

  assign ready_o = (state_q == StIdle);
  assign valid_o = (state_q == StDone);
  assign bus_s_o = res_q;
  assign flags_o = flags_q;

endmodule

// File: doc/alu_multicycle.md
ALU_MULTICYCLE -- requirements
Module: alu_multicycle

Interface
REQ-001 SHALL have parameter BITS, default 8, operand/result width (legal range 2..64).
REQ-002 SHALL have port clk_i  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst_i  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port valid_i  input  1  request valid.
REQ-005 SHALL have port ready_o  output  1  block can accept a request.
REQ-006 SHALL have ports bus_a_i, bus_b_i  input  BITS  operands; bus_b_i is the shift amount for shifts.
REQ-007 SHALL have port control_i  input  4  opcode: 0000 ADD, 0001 SUB, 0010 SHL, 0011 SHR, 0100 OR, 0101 AND, 0110 XOR, 0111 NOT(a), 1000 MUL, 1001 ASR; 1010-1111 illegal.
REQ-008 SHALL have port valid_o  output  1  result valid.
REQ-009 SHALL have port ready_i  input  1  consumer accepts result.
REQ-010 SHALL have port bus_s_o  output  BITS  registered result.
REQ-011 SHALL have port flags_o  output  4  registered flags: [0] Z, [1] V, [2] N, [3] C.

Function
REQ-012 SHALL use FSM states IDLE, EXEC, DONE; ready_o = 1 only in IDLE; valid_o = 1 only in DONE.
REQ-013 SHALL accept a request on an edge with IDLE and valid_i = 1, capturing operands and opcode; inputs are ignored in EXEC/DONE.
REQ-014 Single-cycle ops (ADD, SUB, logic, NOT, illegal, shifts with amount 0) SHALL go IDLE->DONE; valid_o rises 1 cycle after acceptance.
REQ-015 Shifts SHALL execute one bit per cycle in EXEC for k = min(bus_b_i, BITS) cycles; valid_o rises 1+k cycles after acceptance.
REQ-016 MUL SHALL be unsigned shift-add, BITS cycles in EXEC; valid_o rises 1+BITS cycles after acceptance; bus_s_o = low BITS of the product.
REQ-017 In DONE, bus_s_o, flags_o and valid_o SHALL hold stable until ready_i = 1; on that edge the FSM returns to IDLE (new request acceptable on the following edge).
REQ-018 ADD/SUB SHALL compute modulo 2^BITS; SUB = a + ~b + 1.
REQ-019 Z SHALL be (bus_s_o == 0) and N SHALL be bus_s_o[BITS-1] for every opcode.
REQ-020 C SHALL be: ADD carry-out; SUB carry-out of a + ~b + 1 (1 = no borrow); shifts the last bit shifted out (0 if k = 0); MUL 1 iff upper BITS of the product are nonzero; otherwise 0.
REQ-021 V SHALL be signed overflow for ADD/SUB and 0 for all other opcodes.
REQ-022 Shift amounts >= BITS SHALL give SHL/SHR result 0 and ASR result all copies of a[BITS-1], with latency 1+BITS.
REQ-023 Illegal opcodes SHALL complete as single-cycle ops with bus_s_o = 0, flags Z = 1, others 0.

Reset
REQ-024 On rst_i = 1 at an edge, the FSM SHALL enter IDLE, abort any in-flight operation, and set valid_o = 0, bus_s_o = 0, flags_o = 0, internal counters = 0; ready_o = 1 on the following cycle.
REQ-025 rst_i SHALL take priority over valid_i and ready_i on the same edge.

Structure
REQ-026 A shared package alu_pkg SHALL hold the opcode enum, the flag index constants and the FSM state enum.
REQ-027 Flag computation SHALL live in one combinational sub-module alu_flag_gen (inputs: opcode, result, carry, overflow); everything else stays in alu_multicycle.

Verification (BITS = 8)
REQ-028 ADD 0x7F + 0x01 -> bus_s_o 0x80, V=1 N=1 C=0 Z=0, valid_o 1 cycle after acceptance.
REQ-029 SUB 0x05 - 0x05 -> 0x00, Z=1 C=1 V=0 N=0; SHR 0x81 by 1 -> 0x40, C=1, latency 2; SHL 0x01 by 200 -> 0x00, Z=1, latency 9.
REQ-030 MUL 0x10 * 0x11 -> 0x10, C=1, valid_o exactly 9 cycles after acceptance.
REQ-031 Backpressure: ready_i = 0 for 5 cycles in DONE -> bus_s_o/flags_o/valid_o stable, ready_o = 0, valid_i pulses ignored; ready_i = 1 -> IDLE next cycle.
REQ-032 rst_i asserted during MUL cycle 4 -> next cycle IDLE, ready_o = 1, valid_o = 0, bus_s_o = 0x00, flags_o = 0; a following ADD 0x02 + 0x03 returns 0x05.
REQ-033 Opcode 1111 -> bus_s_o 0x00, flags_o = 4'b0001, latency 1.
